// File: rtl/param_seq_detector.sv
// Serial LEN-bit pattern detector with overlap mode
// and a saturating match counter.
module param_seq_detector #(
  parameter int                LEN     = 4,
  parameter logic [LEN-1:0]    PATTERN = 4'b1011,
  parameter bit                OVERLAP = 1'b1,
  parameter int                CNT_W   = 8,
  localparam int               FW      = $clog2(LEN+1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             EN,
  input  logic             CLR,
  input  logic             X_IN,
  output logic             Y_OUT,
  output logic [CNT_W-1:0] DET_CNT,
  output logic [FW-1:0]    FILL
);

  localparam logic [FW-1:0] FULL = FW'(LEN);

  logic [LEN-1:0] hist;
  logic [LEN-1:0] nh;
  logic [FW-1:0]  nf;
  logic           hit;
  logic           cnt_max;

  always_comb begin
    nh      = {hist[LEN-2:0], X_IN};
    nf      = (FILL == FULL) ? FILL : FILL + 1'b1;
    hit     = (nf == FULL) && (nh == PATTERN);
    cnt_max = &DET_CNT;
  end

  // hist may hold stale zeros; FILL gates hits until LEN fresh bits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hist    <= '0;
      FILL    <= '0;
      Y_OUT   <= 1'b0;
      DET_CNT <= '0;
    end else if (CLR) begin
      hist    <= '0;
      FILL    <= '0;
      Y_OUT   <= 1'b0;
      DET_CNT <= '0;
    end else if (EN) begin
      hist  <= nh;
      Y_OUT <= hit;
      FILL  <= (hit && !OVERLAP) ? '0 : nf;
      if (hit && !cnt_max)
        DET_CNT <= DET_CNT + 1'b1;
    end else begin
      Y_OUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_seq_detector.sv
// Bench for param_seq_detector: three configurations
// driven in parallel, checked against a bit-stream model.
module tb_param_seq_detector;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic EN = 1'b1;
  logic CLR = 1'b0;
  logic X_IN = 1'b0;

  logic       y0, y1, y2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [2:0] f0, f1, f2;

  int nchk = 0;
  int nerr = 0;
  bit done = 1'b0;

  always #5 CLK = ~CLK;

  param_seq_detector dut0 (
    .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR), .X_IN(X_IN),
    .Y_OUT(y0), .DET_CNT(c0), .FILL(f0));

  param_seq_detector #(.OVERLAP(1'b0)) dut1 (
    .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR), .X_IN(X_IN),
    .Y_OUT(y1), .DET_CNT(c1), .FILL(f1));

  param_seq_detector #(.OVERLAP(1'b0), .CNT_W(2)) dut2 (
    .CLK(CLK), .nRST(nRST), .EN(EN), .CLR(CLR), .X_IN(X_IN),
    .Y_OUT(y2), .DET_CNT(c2), .FILL(f2));

  // Model: last four bits as an integer, count of fresh bits,
  // match flag and match count per configuration.
  localparam int PAT = 11;
  bit ovl  [3] = '{1'b1, 1'b0, 1'b0};
  int cmax [3] = '{255, 255, 3};
  int mv [3];
  int mn [3];
  int mc [3];
  bit my [3];

  always @(posedge CLK or negedge nRST) begin
    for (int i = 0; i < 3; i++) begin
      int nv;
      int nn;
      bit h;
      nv = (mv[i] * 2 + int'(X_IN)) % 16;
      nn = (mn[i] + 1 > 4) ? 4 : mn[i] + 1;
      h  = (nn == 4) && (nv == PAT);
      if (!nRST || CLR) begin
        mv[i] <= 0;
        mn[i] <= 0;
        mc[i] <= 0;
        my[i] <= 1'b0;
      end else if (EN) begin
        mv[i] <= nv;
        mn[i] <= (h && !ovl[i]) ? 0 : nn;
        my[i] <= h;
        if (h && mc[i] < cmax[i])
          mc[i] <= mc[i] + 1;
      end else begin
        my[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!done) begin
      chk("m0.y", int'(y0), int'(my[0]));
      chk("m0.cnt", int'(c0), mc[0]);
      chk("m0.fill", int'(f0), mn[0]);
      chk("m1.y", int'(y1), int'(my[1]));
      chk("m1.cnt", int'(c1), mc[1]);
      chk("m1.fill", int'(f1), mn[1]);
      chk("m2.y", int'(y2), int'(my[2]));
      chk("m2.cnt", int'(c2), mc[2]);
      chk("m2.fill", int'(f2), mn[2]);
    end
  end

  task automatic step(input logic en, input logic x, input logic clr);
    EN = en;
    X_IN = x;
    CLR = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear();
    step(1'b1, 1'b0, 1'b1);
  endtask

  int pulses;
  logic s7 [7] = '{1, 0, 1, 1, 0, 1, 1};
  logic p4 [4] = '{1, 0, 1, 1};

  initial begin
    // 1: reset with EN=1, X_IN=0
    #21;
    chk("rst.y", int'(y0), 0);
    chk("rst.cnt", int'(c0), 0);
    chk("rst.fill", int'(f0), 0);
    nRST = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk("zeros.fill", int'(f0), 4);
    chk("zeros.y", int'(y0), 0);
    chk("zeros.cnt", int'(c0), 0);

    // 2/3: 1011011 overlap vs non-overlap
    clear();
    for (int i = 0; i < 7; i++) begin
      step(1'b1, s7[i], 1'b0);
      if (i == 3) begin
        chk("ovl.y@4", int'(y0), 1);
        chk("novl.y@4", int'(y1), 1);
      end
      if (i == 6) begin
        chk("ovl.y@7", int'(y0), 1);
        chk("novl.y@7", int'(y1), 0);
      end
    end
    chk("ovl.cnt", int'(c0), 2);
    chk("novl.cnt", int'(c1), 1);
    chk("novl.fill", int'(f1), 3);

    // 4: enable gap with X_IN toggling
    clear();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'(i % 2), 1'b0);
      chk("gap.y", int'(y0), 0);
    end
    step(1'b1, 1'b1, 1'b0);
    chk("gap.y3", int'(y0), 0);
    step(1'b1, 1'b1, 1'b0);
    chk("gap.hit", int'(y0), 1);
    chk("gap.cnt", int'(c0), 1);
    step(1'b0, 1'b0, 1'b0);
    chk("gap.pulse1", int'(y0), 0);

    // 5: saturation on the 2-bit counter
    clear();
    pulses = 0;
    for (int r = 0; r < 5; r++)
      for (int i = 0; i < 4; i++) begin
        step(1'b1, p4[i], 1'b0);
        pulses += int'(y2);
      end
    chk("sat.pulses", pulses, 5);
    chk("sat.cnt", int'(c2), 3);
    chk("sat.cnt8", int'(c1), 5);
    step(1'b1, 1'b1, 1'b1);
    chk("clr.cnt", int'(c2), 0);
    chk("clr.fill", int'(f2), 0);
    chk("clr.y", int'(y2), 0);

    // 6: reset pulse mid-sequence
    clear();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    nRST = 1'b0;
    #2;
    chk("mid.fill", int'(f0), 0);
    nRST = 1'b1;
    #1;
    step(1'b1, 1'b1, 1'b0);
    chk("mid.y", int'(y0), 0);
    chk("mid.fill1", int'(f0), 1);
    chk("mid.cnt", int'(c0), 0);

    @(negedge CLK);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
